popcount_seq: RTL and testbench
===============================

// Module: popcount_seq
// PURPOSE
//   Multi-cycle population counter: accepts a DATA_W-bit word over a valid/ready
//   handshake, counts ones (or zeros, per mode) CHUNK_W bits per cycle, and
//   returns the count over a second valid/ready handshake. This is the
//   parametrised, flow-controlled successor to the fixed 16-bit ones counter.
//   It sits between a word producer and a consumer that tolerates multi-cycle latency.
// PARAMETERS
//   DATA_W   16  input word width; must be a multiple of CHUNK_W (elaboration error otherwise)
//   CHUNK_W   4  bits counted per COUNT cycle; 1..DATA_W
//   (local) NCHUNK = DATA_W/CHUNK_W ; CNT_W = $clog2(DATA_W+1)
// PORTS
//   clk        in   1       clock; all logic on rising edge
//   reset      in   1       synchronous, active-high reset
//   in_valid   in   1       input word valid
//   in_ready   out  1       block can accept a word
//   in_data    in   DATA_W  word to count
//   in_mode    in   1       0 = count ones, 1 = count zeros; sampled with in_data
//   out_valid  out  1       out_count valid
//   out_ready  in   1       consumer accepts result
//   out_count  out  CNT_W   result; width holds DATA_W exactly (16 -> 5 bits)
//   busy       out  1       high in COUNT or DONE
//   stat_words out  16      [POPCNT_STATS_EN only] results delivered
// BEHAVIOUR
//   - Reset: state=IDLE, in_ready=1, out_valid=0, out_count=0, busy=0,
//     accumulator/shift reg=0, stat_words=0. Reset mid-operation aborts and
//     discards the in-flight word; no out_valid is produced for it.
//   - FSM: IDLE -> COUNT on in_valid&&in_ready; COUNT -> DONE after NCHUNK
//     cycles; DONE -> IDLE on out_valid&&out_ready.
//   - in_ready = (state==IDLE). No acceptance in COUNT/DONE; in_valid there ignored.
//   - Accept edge: shift reg <= in_mode ? ~in_data : in_data; acc <= 0; chunk idx <= 0.
//   - Each COUNT edge: acc <= acc + popcount(shreg[CHUNK_W-1:0]); shreg >>= CHUNK_W;
//     idx++. On the edge with idx==NCHUNK-1 move to DONE, out_count <= final acc.
//   - Latency: out_valid rises exactly NCHUNK edges after the accept edge
//     (16/4 -> 4). Next accept at earliest 1 edge after output handshake;
//     throughput = 1 word per NCHUNK+2 cycles under no backpressure.
//   - DONE: out_valid=1, out_count stable until out_ready; backpressure of any
//     length holds result unchanged. out_count retains last value after handshake.
//   - Arithmetic: acc is CNT_W bits, never overflows (max DATA_W).
//   - Simultaneous in_valid in DONE with out_ready: result handshakes, new word
//     NOT accepted that edge (in_ready=0); accepted next cycle in IDLE.
//   - in_data/in_mode changes after accept have no effect on the current count.
// CONFIGURATION
//   POPCNT_STATS_EN defined: stat_words port present; increments by 1 on each
//     out_valid&&out_ready, saturates at 16'hFFFF, cleared only by reset.
//   Not defined: port and counter absent; all other behaviour identical.
// TESTING
//   1 reset held 3 cycles, then released -> in_ready=1, out_valid=0, out_count=0, busy=0.
//   2 in_data=16'hFFFF mode0, out_ready=1 -> out_valid exactly 4 edges after accept, out_count=16.
//   3 in_data=16'h0000 mode1 -> 16; 16'hA5A5 mode0 -> 8; 16'hA5A5 mode1 -> 8; 16'h0001 mode1 -> 15.
//   4 16'h00F0 with out_ready low 6 cycles -> out_valid/out_count=4 held, in_ready=0, in_valid ignored.
//   5 reset asserted on 2nd COUNT cycle, new word 16'h0003 next -> only result 2 ever seen.
//   6 200 random words, random mode/backpressure, CHUNK_W=1,4,16 -> matches model;
//     with POPCNT_STATS_EN stat_words=200.

Source files
------------

// File: rtl/popcount_seq.sv
// popcount_seq: counts ones (mode 0) or zeros (mode 1) of a DATA_W-bit word, CHUNK_W bits per cycle, valid/ready on both sides.
// Optional macro POPCNT_STATS_EN adds stat_words, a saturating count of delivered results.
module popcount_seq #(
  parameter int DATA_W  = 16,
  parameter int CHUNK_W = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [DATA_W-1:0]           in_data,
  input  logic                        in_mode,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [$clog2(DATA_W+1)-1:0] out_count,
  output logic                        busy
`ifdef POPCNT_STATS_EN
  ,
  output logic [15:0]                 stat_words
`endif
);

  localparam int NCHUNK = DATA_W / CHUNK_W;
  localparam int CNT_W  = $clog2(DATA_W + 1);
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

  if ((CHUNK_W < 1) || (CHUNK_W > DATA_W)) begin : g_bad_chunk_range
    $error("popcount_seq: CHUNK_W must be in 1..DATA_W");
  end
  if ((DATA_W % CHUNK_W) != 0) begin : g_bad_chunk_div
    $error("popcount_seq: DATA_W must be a multiple of CHUNK_W");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_COUNT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t             r_state;
  logic [DATA_W-1:0]  r_shreg;
  logic [CNT_W-1:0]   r_acc;
  logic [IDX_W-1:0]   r_idx;
  logic [CNT_W-1:0]   r_out_count;
  logic               r_out_valid;
  logic               r_in_ready;
  logic               r_busy;

  logic [CNT_W-1:0]   w_chunk_cnt;
  logic [CNT_W-1:0]   w_acc_next;
  logic               w_accept;
  logic               w_deliver;

  always_comb begin
    w_chunk_cnt = '0;
    for (int i = 0; i < CHUNK_W; i++) begin
      w_chunk_cnt = w_chunk_cnt + CNT_W'(r_shreg[i]);
    end
  end

  // acc never exceeds DATA_W, which CNT_W holds exactly.
  assign w_acc_next = r_acc + w_chunk_cnt;
  assign w_accept   = in_valid && r_in_ready;
  assign w_deliver  = r_out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_shreg     <= '0;
      r_acc       <= '0;
      r_idx       <= '0;
      r_out_count <= '0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_shreg    <= in_mode ? ~in_data : in_data;
            r_acc      <= '0;
            r_idx      <= '0;
            r_state    <= S_COUNT;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
          end
        end
        S_COUNT: begin
          r_acc   <= w_acc_next;
          r_shreg <= r_shreg >> CHUNK_W;
          r_idx   <= r_idx + 1'b1;
          if (r_idx == LAST_IDX) begin
            r_state     <= S_DONE;
            r_out_valid <= 1'b1;
            r_out_count <= w_acc_next;
          end
        end
        S_DONE: begin
          // in_ready stays low here, so a word offered alongside the result handshake waits a cycle.
          if (w_deliver) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_count = r_out_count;
  assign busy      = r_busy;

`ifdef POPCNT_STATS_EN
  logic [15:0] r_stat_words;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stat_words <= '0;
    end else if (w_deliver && (r_stat_words != 16'hFFFF)) begin
      r_stat_words <= r_stat_words + 16'd1;
    end
  end

  assign stat_words = r_stat_words;
`endif

endmodule

// File: tb/tb_popcount_seq.sv
// Bench for popcount_seq: three lanes (CHUNK_W = 1, 4, 16) with directed vectors and a randomized model check.
module tb_popcount_seq;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] in_valid;
  logic [2:0] in_ready;
  logic [2:0] in_mode;
  logic [2:0] out_valid;
  logic [2:0] out_ready;
  logic [2:0] busy;
  logic [15:0] in_data [3];
  logic [4:0]  out_count [3];
`ifdef POPCNT_STATS_EN
  logic [15:0] stat_words [3];
`endif

  int n_checks = 0;
  int n_errors = 0;
  int lat [3] = '{16, 4, 1};

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_lane
    localparam int CW = (g == 0) ? 1 : ((g == 1) ? 4 : 16);
    popcount_seq #(.DATA_W(16), .CHUNK_W(CW)) u_dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .in_data   (in_data[g]),
      .in_mode   (in_mode[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .out_count (out_count[g]),
      .busy      (busy[g])
`ifdef POPCNT_STATS_EN
      ,
      .stat_words(stat_words[g])
`endif
    );
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  // Called at the negedge right after the accept edge; counts edges until out_valid.
  task automatic wait_result(input int k, input int exp_cnt, input int exp_lat, input string nm);
    int  edges;
    bit  seen;
    edges = 0;
    seen  = 1'b0;
    while (!seen && edges < 64) begin
      @(posedge clk);
      edges++;
      #1;
      seen = out_valid[k];
    end
    chk({nm, "_timeout"}, {31'd0, seen}, 32'd1);
    chk({nm, "_latency"}, edges, exp_lat);
    chk({nm, "_count"}, {27'd0, out_count[k]}, exp_cnt);
  endtask

  task automatic run_word(input int k, input logic [15:0] d, input logic m, input logic ordy,
                          input int exp_cnt, input int exp_lat, input string nm);
    @(negedge clk);
    chk({nm, "_in_ready"}, {31'd0, in_ready[k]}, 32'd1);
    in_valid[k]  = 1'b1;
    in_data[k]   = d;
    in_mode[k]   = m;
    out_ready[k] = ordy;
    @(posedge clk);
    @(negedge clk);
    // Changing inputs after acceptance must not disturb the count.
    in_valid[k] = 1'b0;
    in_data[k]  = ~d;
    in_mode[k]  = ~m;
    wait_result(k, exp_cnt, exp_lat, nm);
  endtask

  typedef struct {
    logic [15:0] d;
    logic        m;
    int          exp_cnt;
  } vec_t;

  vec_t vecs [5];
  int   bad_seen;
  bit   mon_en = 1'b0;

  always @(negedge clk) begin
    if (mon_en && out_valid[1] && (out_count[1] != 5'd2)) bad_seen++;
  end

  int          sent [3];
  int          got  [3];
  int          pend [3];
  bit          pend_v [3];
  int          exp_c;
  bit          all_done;
  logic [31:0] held;

  initial begin
    vecs[0] = '{16'hFFFF, 1'b0, 16};
    vecs[1] = '{16'h0000, 1'b1, 16};
    vecs[2] = '{16'hA5A5, 1'b0, 8};
    vecs[3] = '{16'hA5A5, 1'b1, 8};
    vecs[4] = '{16'h0001, 1'b1, 15};

    reset     = 1'b1;
    in_valid  = '0;
    in_mode   = '0;
    out_ready = 3'b111;
    for (int k = 0; k < 3; k++) in_data[k] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_in_ready", {29'd0, in_ready}, 32'd7);
    chk("rst_out_valid", {29'd0, out_valid}, 32'd0);
    chk("rst_busy", {29'd0, busy}, 32'd0);
    for (int k = 0; k < 3; k++) chk($sformatf("rst_out_count%0d", k), {27'd0, out_count[k]}, 32'd0);
`ifdef POPCNT_STATS_EN
    chk("rst_stat_words", {16'd0, stat_words[1]}, 32'd0);
`endif

    // Table vectors on every lane; latency depends on chunk width.
    for (int k = 0; k < 3; k++) begin
      for (int v = 0; v < 5; v++) begin
        run_word(k, vecs[v].d, vecs[v].m, 1'b1, vecs[v].exp_cnt, lat[k], $sformatf("vec%0d_lane%0d", v, k));
        chk($sformatf("vec%0d_lane%0d_busy", v, k), {31'd0, busy[k]}, 32'd1);
        @(posedge clk);
        #1;
        chk($sformatf("vec%0d_lane%0d_idle", v, k), {30'd0, in_ready[k], out_valid[k]}, 32'd2);
      end
    end

    // Backpressure: result held, input ignored.
    run_word(1, 16'h00F0, 1'b0, 1'b0, 4, 4, "bp");
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      in_valid[1] = 1'b1;
      in_data[1]  = 16'(($urandom));
      in_mode[1]  = 1'b0;
      @(posedge clk);
      #1;
      held = {24'd0, out_valid[1], in_ready[1], busy[1], out_count[1]};
      chk($sformatf("bp_hold%0d", i), held, {24'd0, 1'b1, 1'b0, 1'b1, 5'd4});
    end
    @(negedge clk);
    out_ready[1] = 1'b1;
    in_valid[1]  = 1'b1;
    in_data[1]   = 16'h000F;
    in_mode[1]   = 1'b0;
    @(posedge clk);
    #1;
    chk("bp_handshake_no_accept", {25'd0, in_ready[1], out_valid[1], out_count[1]}, {25'd0, 1'b1, 1'b0, 5'd4});
    @(posedge clk);
    #1;
    chk("bp_accept_next", {30'd0, busy[1], in_ready[1]}, 32'd2);
    @(negedge clk);
    in_valid[1] = 1'b0;
    wait_result(1, 4, 4, "bp_next");
    @(posedge clk);

    // Reset on the second COUNT cycle aborts the word.
    bad_seen = 0;
    mon_en   = 1'b1;
    @(negedge clk);
    in_valid[1] = 1'b1;
    in_data[1]  = 16'hFFFF;
    in_mode[1]  = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    in_valid[1] = 1'b0;
    reset       = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("abort_state", {27'd0, out_valid[1], busy[1], in_ready[1], 2'd0}, {27'd0, 1'b0, 1'b0, 1'b1, 2'd0});
    chk("abort_count", {27'd0, out_count[1]}, 32'd0);
    run_word(1, 16'h0003, 1'b0, 1'b1, 2, 4, "abort_next");
    repeat (20) @(posedge clk);
    @(negedge clk);
    mon_en = 1'b0;
    chk("abort_no_stale_result", bad_seen, 32'd0);

    // Randomized phase against a count-based reference.
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      sent[k] = 0;
      got[k] = 0;
      pend[k] = 0;
      pend_v[k] = 1'b0;
    end
    all_done = 1'b0;
    for (int cyc = 0; cyc < 30000 && !all_done; cyc++) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        in_valid[k]  = (sent[k] < 200) && ($urandom_range(0, 3) != 0);
        in_data[k]   = 16'($urandom);
        in_mode[k]   = 1'($urandom_range(0, 1));
        out_ready[k] = ($urandom_range(0, 3) != 0);
      end
      #1;
      all_done = 1'b1;
      for (int k = 0; k < 3; k++) begin
        if (out_valid[k] && out_ready[k]) begin
          chk($sformatf("rand_lane%0d_word%0d", k, got[k]), {26'd0, pend_v[k], out_count[k]}, {26'd0, 1'b1, 5'(pend[k])});
          pend_v[k] = 1'b0;
          got[k]++;
        end
        if (in_valid[k] && in_ready[k]) begin
          exp_c = in_mode[k] ? (16 - $countones(in_data[k])) : $countones(in_data[k]);
          chk($sformatf("rand_lane%0d_overlap", k), {31'd0, pend_v[k]}, 32'd0);
          pend[k]   = exp_c;
          pend_v[k] = 1'b1;
          sent[k]++;
        end
        if (got[k] < 200) all_done = 1'b0;
      end
    end
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      in_valid[k] = 1'b0;
      chk($sformatf("rand_lane%0d_delivered", k), got[k], 32'd200);
`ifdef POPCNT_STATS_EN
      chk($sformatf("rand_lane%0d_stat_words", k), {16'd0, stat_words[k]}, 32'd200);
`endif
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
